// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word RMW for RAM and raw MMIO access
module mem_access_unit #(
    parameter logic [19:0] MMIO_HI = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdin,
    output logic        bus_we,
    input  logic [31:0] bus_rd
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;

    logic        req_err;
    logic        req_mmio;
    logic        req_rmw;
    logic        mmio_q;
    logic        rmw_q;
    logic [31:0] word_adr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_mmio = (req_addr[31:12] == MMIO_HI);
    assign req_rmw  = req_we && !req_mmio && (req_funct3 == 3'd0 || req_funct3 == 3'd1);
    assign mmio_q   = (addr_q[31:12] == MMIO_HI);
    assign rmw_q    = we_q && !mmio_q && (f3_q == 3'd0 || f3_q == 3'd1);
    assign word_adr = {addr_q[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'd1, 3'd5: req_err = req_addr[0];
            3'd2:       req_err = (req_addr[1:0] != 2'b00);
            3'd3, 3'd6, 3'd7: req_err = 1'b1;
            default:    req_err = 1'b0;
        endcase
        if (req_we && (req_funct3 == 3'd4 || req_funct3 == 3'd5))
            req_err = 1'b1;
    end

    // MMIO registers sit in the low lanes, so no lane selection there
    always_comb begin
        byte_sel = bus_rd[7:0];
        if (!mmio_q) begin
            case (addr_q[1:0])
                2'd0: byte_sel = bus_rd[7:0];
                2'd1: byte_sel = bus_rd[15:8];
                2'd2: byte_sel = bus_rd[23:16];
                default: byte_sel = bus_rd[31:24];
            endcase
        end
        half_sel = (mmio_q || !addr_q[1]) ? bus_rd[15:0] : bus_rd[31:16];
        case (f3_q)
            3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_val = {24'd0, byte_sel};
            3'd5:    load_val = {16'd0, half_sel};
            default: load_val = bus_rd;
        endcase
    end

    always_comb begin
        merged = data_q;
        if (f3_q == 3'd1) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_next = state;
        bus_adr    = 32'd0;
        bus_wdin   = 32'd0;
        bus_we     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)       state_next = DONE;
                    else if (!req_we)  state_next = LOAD;
                    else if (req_rmw)  state_next = RMW_RD;
                    else               state_next = STORE;
                end
            end
            LOAD: begin
                bus_adr    = mmio_q ? addr_q : word_adr;
                state_next = DONE;
            end
            RMW_RD: begin
                bus_adr    = word_adr;
                state_next = STORE;
            end
            STORE: begin
                bus_we     = 1'b1;
                bus_adr    = rmw_q ? word_adr : addr_q;
                bus_wdin   = rmw_q ? merged : wdata_q;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                f3_q    <= req_funct3;
                we_q    <= req_we;
                err_q   <= req_err;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                data_q  <= 32'd0;
            end
            if (state == LOAD)   data_q <= load_val;
            if (state == RMW_RD) data_q <= bus_rd;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) && err_q;
    assign resp_rdata = (state == DONE && !we_q && !err_q) ? data_q : 32'd0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MMIO_HI, default 20'hFFFFF, the upper 20 address bits that mark the MMIO region (no lane shifting, no read-modify-write).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline MEM-stage request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32 width code: 0 b, 1 h, 2 w, 4 bu, 5 hu.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-012 SHALL have port resp_err  output  1  misaligned/illegal request, valid with resp_valid.
REQ-013 SHALL have port bus_adr  output  32  address to data-memory responder.
REQ-014 SHALL have port bus_wdin  output  32  write word to responder.
REQ-015 SHALL have port bus_we  output  1  word write enable to responder.
REQ-016 SHALL have port bus_rd  input  32  responder read data, combinational from bus_adr, same cycle.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RMW_RD, STORE, DONE.
REQ-018 SHALL assert req_ready only in IDLE; req_valid outside IDLE ignored, request not queued.
REQ-019 SHALL latch funct3, we, addr, wdata on acceptance (IDLE & req_valid).
REQ-020 SHALL flag error when funct3 in {3,6,7}, funct3 halfword with addr[0]=1, or word with addr[1:0]!=0; stores with funct3 4/5 also error.
REQ-021 Error path: IDLE -> DONE; resp_err=1, resp_rdata=0, no bus cycle.
REQ-022 Load path: IDLE -> LOAD -> DONE; resp_valid 2 cycles after acceptance.
REQ-023 In LOAD, bus_adr = {addr[31:2],2'b00} for RAM, full addr for MMIO; bus_rd registered into result.
REQ-024 RAM loads SHALL select byte lane addr[1:0] / half lane addr[1], sign-extend for b/h, zero-extend for bu/hu.
REQ-025 MMIO loads SHALL take bits [7:0]/[15:0] of bus_rd regardless of addr[1:0], then extend per funct3; lw passes bus_rd unchanged.
REQ-026 sw and all MMIO stores: IDLE -> STORE -> DONE; resp_valid 2 cycles after acceptance; bus_wdin = wdata unshifted, bus_adr = addr.
REQ-027 RAM sb/sh: IDLE -> RMW_RD -> STORE -> DONE; resp_valid 3 cycles after acceptance.
REQ-028 In RMW_RD, bus_adr = word address, bus_we=0, bus_rd captured as old word.
REQ-029 In STORE after RMW_RD, bus_wdin = old word with addressed byte/half lane replaced by wdata[7:0]/[15:0]; other lanes unchanged.
REQ-030 bus_we SHALL be 1 only in STORE, exactly one cycle per store; never for loads or errors.
REQ-031 Outside LOAD/RMW_RD/STORE, bus_adr, bus_wdin SHALL be 0.
REQ-032 DONE SHALL last one cycle, assert resp_valid, then return to IDLE; next request acceptable the following cycle.
REQ-033 resp_rdata SHALL be 0 for stores; resp_rdata and resp_err SHALL hold 0 when resp_valid=0.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-RMW; request aborted, no response.
REQ-035 After reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bus_we=0, bus_adr=0, bus_wdin=0.
REQ-036 rst SHALL take precedence over a simultaneous req_valid.

Verification
REQ-037 RAM word 0x100 = 0x11223344; sb addr 0x102 data 0xAB -> RMW_RD then STORE bus_wdin=0x11AB3344, resp_valid at +3, later lw 0x100 -> 0x11AB3344.
REQ-038 RAM word 0x200 = 0x80F0_7FFF; lb 0x202 -> 0xFFFFFFF0; lbu 0x202 -> 0x000000F0; lh 0x200 -> 0x00007FFF; lhu 0x202 -> 0x000080F0, each at +2.
REQ-039 sh addr 0xFFFFF062 data 0x005A -> single STORE, bus_adr=0xFFFFF062, bus_wdin=0x0000005A, no RMW_RD.
REQ-040 lhu 0xFFFFF072 with bus_rd=0x000000C3 -> resp_rdata=0x000000C3 (no lane shift).
REQ-041 lw 0x101 -> resp_err=1 at +1, bus_we never asserted; funct3=3 -> same.
REQ-042 rst asserted during RMW_RD of sb -> no bus_we, no resp_valid, IDLE with req_ready=1 next cycle.
